i2c_master_core: RTL

Byte-level I2C master engine sitting directly downstream of the APB slave in the APB–I2C bridge. Consumes the control bytes `i2c_con1`/`i2c_con2` and write data `Din` from the APB slave, runs one complete I2C transaction (START, address+R/W, 1–4 data bytes, STOP) on open-drain SCL/SDA, and returns read data `Dout`, the `ready` handshake and `i2c_stat` to the APB slave.

---
 rtl/i2c_master_core_if.sv | 24 ++
 rtl/i2c_master_core.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_core_if.sv
// Control/status and open-drain line bundle of the byte-level I2C master core.
// The master modport is the core's view; slave is the APB-side/bus-side view.
interface i2c_master_core_if;
   logic [7:0]  i2c_con1;
   logic [7:0]  i2c_con2;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        ready;
   logic [7:0]  i2c_stat;
   logic        scl_oe;
   logic        sda_oe;
   logic        scl_i;
   logic        sda_i;

   modport master (
      input  i2c_con1, i2c_con2, Din, scl_i, sda_i,
      output Dout, ready, i2c_stat, scl_oe, sda_oe
   );

   modport slave (
      output i2c_con1, i2c_con2, Din, scl_i, sda_i,
      input  Dout, ready, i2c_stat, scl_oe, sda_oe
   );
endinterface

// File: rtl/i2c_master_core.sv
// Byte-level I2C master: one START/addr/1-4 bytes/STOP transaction per go edge, ready low (11+9N)*4Q cycles.
// I2C_CLK_STRETCH_EN: SCL high phase waits for the sensed line to go high before timing starts.
module i2c_master_core #(
   parameter int DIV_BASE = 4
) (
   input  logic              PCLK,
   input  logic              PRESET,
   i2c_master_core_if.master bus
);
   localparam int QW = $clog2(DIV_BASE * 8 + 1);

   typedef enum logic [3:0] {
      IDLE, START, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP
   } state_t;

   state_t        state;
   logic          go_q;
   logic [QW-1:0] q_len;
   logic [QW-1:0] qcnt;
   logic [1:0]    ph;
   logic [1:0]    byte_idx;
   logic [1:0]    last_idx;
   logic [2:0]    bit_idx;
   logic [7:0]    addr_rw;
   logic [7:0]    rx;
   logic [31:0]   wdata;
   logic [31:0]   dout;
   logic          scl_oe, sda_oe, ready;
   logic          busy, done, anack, dnack, abort;
   logic [2:0]    nbytes;

   logic          enable, go_rise, tick, bit_state, abort_req, stretch_hold, tx_pull, cfg_unused;

   assign enable    = bus.i2c_con1[1];
   assign go_rise   = bus.i2c_con1[0] & ~go_q;
   assign tick      = (qcnt == q_len - QW'(1));
   assign bit_state = state inside {ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK};
   assign abort_req = abort | ~enable;

`ifdef I2C_CLK_STRETCH_EN
   assign stretch_hold = bit_state && (ph == 2'd2) && (qcnt == '0) && !bus.scl_i;
   assign cfg_unused   = ^bus.i2c_con1[5:4];
`else
   assign stretch_hold = 1'b0;
   assign cfg_unused   = ^{bus.i2c_con1[5:4], bus.scl_i};
`endif

   // Value to pull SDA with during the low phase of the current bit slot.
   always_comb begin
      tx_pull = 1'b0;
      case (state)
         ADDR:    tx_pull = ~addr_rw[~bit_idx];
         WR_BYTE: tx_pull = ~wdata[{byte_idx, ~bit_idx}];
         RD_ACK:  tx_pull = (byte_idx != last_idx);
         default: tx_pull = 1'b0;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state    <= IDLE;
         go_q     <= 1'b0;
         q_len    <= '0;
         qcnt     <= '0;
         ph       <= '0;
         byte_idx <= '0;
         last_idx <= '0;
         bit_idx  <= '0;
         addr_rw  <= '0;
         rx       <= '0;
         wdata    <= '0;
         dout     <= '0;
         scl_oe   <= 1'b0;
         sda_oe   <= 1'b0;
         ready    <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         anack    <= 1'b0;
         dnack    <= 1'b0;
         abort    <= 1'b0;
         nbytes   <= '0;
      end else begin
         go_q <= bus.i2c_con1[0];
         if (state != IDLE && state != STOP && !enable)
            abort <= 1'b1;

         if (state == IDLE) begin
            if (go_rise && enable) begin
               state    <= START;
               ready    <= 1'b0;
               busy     <= 1'b1;
               done     <= 1'b0;
               anack    <= 1'b0;
               dnack    <= 1'b0;
               abort    <= 1'b0;
               nbytes   <= '0;
               addr_rw  <= {bus.i2c_con2[6:0], bus.i2c_con2[7]};
               wdata    <= bus.Din;
               last_idx <= bus.i2c_con1[7:6];
               q_len    <= QW'(DIV_BASE << bus.i2c_con1[3:2]);
               qcnt     <= '0;
               ph       <= '0;
               byte_idx <= '0;
               bit_idx  <= '0;
            end
         end else if (!stretch_hold) begin
            qcnt <= tick ? '0 : qcnt + QW'(1);
            if (tick)
               ph <= ph + 2'd1;

            case (state)
               START: if (tick) begin
                  if (ph == 2'd1) sda_oe <= 1'b1;
                  if (ph == 2'd2) scl_oe <= 1'b1;
                  if (ph == 2'd3) state  <= abort_req ? STOP : ADDR;
               end
               STOP: begin
                  if (ph == 2'd0 && qcnt == '0) sda_oe <= 1'b1;
                  if (tick && ph == 2'd0) scl_oe <= 1'b0;
                  if (tick && ph == 2'd1) sda_oe <= 1'b0;
                  if (tick && ph == 2'd3) begin
                     state <= IDLE;
                     ready <= 1'b1;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
               default: begin
                  if (ph == 2'd0 && qcnt == '0) sda_oe <= tx_pull;
                  if (ph == 2'd3 && qcnt == '0) rx <= {rx[6:0], bus.sda_i};
                  // Abort is taken only once the SCL low phase has run its full length.
                  if (tick && ph == 2'd1) begin
                     if (abort_req) begin
                        state <= STOP;
                        ph    <= 2'd0;
                     end else begin
                        scl_oe <= 1'b0;
                     end
                  end
                  if (tick && ph == 2'd3) begin
                     scl_oe <= 1'b1;
                     case (state)
                        ADDR: begin
                           bit_idx <= bit_idx + 3'd1;
                           if (bit_idx == 3'd7) state <= ADDR_ACK;
                        end
                        ADDR_ACK: begin
                           if (rx[0]) begin
                              anack <= 1'b1;
                              state <= STOP;
                           end else begin
                              state <= addr_rw[0] ? RD_BYTE : WR_BYTE;
                           end
                        end
                        WR_BYTE: begin
                           bit_idx <= bit_idx + 3'd1;
                           if (bit_idx == 3'd7) state <= WR_ACK;
                        end
                        WR_ACK: begin
                           if (rx[0]) begin
                              dnack <= 1'b1;
                              state <= STOP;
                           end else begin
                              nbytes <= nbytes + 3'd1;
                              if (byte_idx == last_idx) begin
                                 state <= STOP;
                              end else begin
                                 byte_idx <= byte_idx + 2'd1;
                                 state    <= WR_BYTE;
                              end
                           end
                        end
                        RD_BYTE: begin
                           bit_idx <= bit_idx + 3'd1;
                           if (bit_idx == 3'd7) begin
                              dout[{byte_idx, 3'b000} +: 8] <= rx;
                              state <= RD_ACK;
                           end
                        end
                        RD_ACK: begin
                           nbytes <= nbytes + 3'd1;
                           if (byte_idx == last_idx) begin
                              state <= STOP;
                           end else begin
                              byte_idx <= byte_idx + 2'd1;
                              state    <= RD_BYTE;
                           end
                        end
                        default: ;
                     endcase
                  end
               end
            endcase
         end
      end
   end

   assign bus.Dout     = dout;
   assign bus.ready    = ready;
   assign bus.i2c_stat = {nbytes, abort, dnack, anack, done, busy};
   assign bus.scl_oe   = scl_oe;
   assign bus.sda_oe   = sda_oe;
endmodule
